float_div: RTL and testbench
============================

// Module: float_div
// PURPOSE
//  Sequential IEEE-754 single-precision divider, out_result = flt_A / flt_B; inverse of the float multiplier.
//  Bit-serial restoring mantissa division, one quotient bit per clock; valid/ready handshake on both sides.
//  Sits beside the multiplier in the FP datapath and shares its operand/result formats.
// PARAMETERS
//  EXP_W   8   exponent field width
//  FRAC_W  23  stored fraction width; BIAS = 2**(EXP_W-1)-1
// PORTS
//  clk         in   1              clock, rising edge
//  res         in   1              synchronous active-low reset
//  in_valid    in   1              operands present
//  in_ready    out  1              high only in IDLE
//  flt_A       in   1+EXP_W+FRAC_W dividend
//  flt_B       in   1+EXP_W+FRAC_W divisor
//  out_valid   out  1              result present; held until accepted
//  out_ready   in   1              consumer takes result
//  out_result  out  1+EXP_W+FRAC_W quotient
//  out_flags   out  4              {invalid, div_by_zero, overflow, underflow}
// BEHAVIOUR
//  - Reset: one clock and reset only; res is synchronous, active-low. res=0 at an edge -> state IDLE,
//    out_valid=0, out_result=0, out_flags=0, divider regs cleared. Applies mid-operation; the op is discarded.
//  - FSM: IDLE -> CHECK -> DIV (FRAC_W+4 cycles) -> NORM -> ROUND -> DONE -> IDLE.
//  - IDLE: in_valid&&in_ready at an edge latches flt_A/flt_B -> CHECK. Input changes after acceptance have no effect.
//  - CHECK classifies operands. Denormals are flushed to zero. Specials go direct to DONE; NaN sign is 0.
//    - NaN operand, 0/0, inf/inf -> 0x7FC00000, invalid.
//    - finite nonzero/0 -> signed inf, div_by_zero.
//    - inf/finite -> signed inf.
//    - 0/finite or finite/inf -> signed zero.
//  - Sign = sA^sB. Exponent held signed, EXP_W+2 bits: eA-eB+BIAS.
//  - DIV: restoring division of 1.fA by 1.fB, FRAC_W+4 quotient bits. Sticky = OR of any nonzero final remainder.
//  - NORM: if the quotient MSB is 0, shift left 1 and decrement the exponent. Yields 1.f, G, R, S.
//  - ROUND: see CONFIGURATION. Mantissa carry-out renormalises and increments the exponent.
//    - exp >= 2**EXP_W-1 -> signed inf, overflow.
//    - exp <= 0 -> signed zero, underflow (flush, no denormal output).
//  - DONE: out_valid=1; out_result/out_flags stable while out_ready=0. On the handshake edge -> IDLE;
//    in_ready rises the next cycle (no same-cycle re-accept).
//  - Latency, accepting edge to first cycle out_valid=1: FRAC_W+7 edges (30) for normal ops, 1 edge for specials.
//    Timing is data-independent within each class.
//  - in_valid while busy is ignored. out_ready outside DONE is ignored.
// CONFIGURATION
//  FDIV_RNE_EN defined:   round-to-nearest-even. Increment if G && (R||S||lsb).
//  FDIV_RNE_EN undefined: truncate (round toward zero). ROUND state kept, so latency is unchanged.
// STRUCTURE
//  - Package fdiv_pkg holds:
//    - state enum (IDLE, CHECK, DIV, NORM, ROUND, DONE);
//    - EXP_W/FRAC_W/BIAS defaults;
//    - QNAN and INF constants;
//    - flag bit indices;
//    - classify function returning {is_zero, is_inf, is_nan}.
//  - Sub-module fdiv_mant_core: iterative restoring mantissa divider with start/done.
//    Produces quotient bits and sticky. Top level handles FSM, exponent, specials and rounding.
// TESTING
//  1. 0x40C00000 / 0x40000000 -> 0x40400000, flags 0, out_valid exactly 30 edges after accept.
//  2. 0x3F800000 / 0x40400000 -> 0x3EAAAAAB with FDIV_RNE_EN; 0x3EAAAAAA without.
//  3. 0/0 -> 0x7FC00000, invalid, latency 1. 0x3F800000/0 -> 0x7F800000, div_by_zero. 0xBF800000/0 -> 0xFF800000.
//  4. 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, overflow. 0x00800000 / 0x40000000 -> 0x00000000, underflow.
//  5. Hold out_ready=0 for 10 cycles in DONE, pulsing in_valid meanwhile.
//     -> result stable, no new accept. After handshake, in_ready=1 next cycle; back-to-back op correct.
//  6. res=0 for 1 edge during DIV (cycle 10) -> out_valid=0, IDLE. Next op 0x41200000/0x40A00000 -> 0x40000000.

Source files
------------

// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared states, default widths, constants and operand classification for float_div
package fdiv_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, ROUND, DONE} fdiv_state_t;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_FRAC_W = 23;
  localparam int DEF_BIAS   = (1 << (DEF_EXP_W - 1)) - 1;

  // Default-format special encodings (sign bit 0).
  localparam logic [DEF_EXP_W+DEF_FRAC_W:0] QNAN =
    {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_FRAC_W-1){1'b0}}};
  localparam logic [DEF_EXP_W+DEF_FRAC_W:0] INF =
    {1'b0, {DEF_EXP_W{1'b1}}, {DEF_FRAC_W{1'b0}}};

  // Bit positions inside out_flags.
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_DIVZ    = 2;
  localparam int FLAG_OVF     = 1;
  localparam int FLAG_UDF     = 0;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fdiv_class_t;

  // Width-independent classification; a zero exponent field counts as zero,
  // so denormals are flushed.
  function automatic fdiv_class_t classify(input logic exp_zero, input logic exp_ones,
                                           input logic frac_zero);
    fdiv_class_t c;
    c.is_zero = exp_zero;
    c.is_inf  = exp_ones && frac_zero;
    c.is_nan  = exp_ones && !frac_zero;
    return c;
  endfunction

endpackage

// File: rtl/fdiv_mant_core.sv
// rtl/fdiv_mant_core.sv - iterative restoring mantissa divider, one quotient bit per clock
module fdiv_mant_core #(
  parameter int FRAC_W = 23
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  input  logic [FRAC_W:0]   mant_a_i,
  input  logic [FRAC_W:0]   mant_b_i,
  output logic              done_o,
  output logic [FRAC_W+3:0] quo_o,
  output logic              sticky_o
);

  localparam int NQ = FRAC_W + 4;
  localparam int RW = FRAC_W + 2;
  localparam int CW = $clog2(NQ);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rem_q, rem_d, div_q, div_d, diff;
  logic [NQ-1:0] quo_q, quo_d;
  logic          sticky_q, sticky_d;
  logic          ge, last;

  // One restoring step per cycle; the final partial remainder feeds sticky.
  always_comb begin
    ge       = (rem_q >= div_q);
    diff     = ge ? (rem_q - div_q) : rem_q;
    last     = busy_q && (cnt_q == CW'(NQ - 1));
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    sticky_d = sticky_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      rem_d    = {1'b0, mant_a_i};
      div_d    = {1'b0, mant_b_i};
      quo_d    = '0;
      sticky_d = 1'b0;
    end else if (busy_q) begin
      quo_d = {quo_q[NQ-2:0], ge};
      rem_d = diff << 1;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        busy_d   = 1'b0;
        sticky_d = |diff;
      end
    end
  end

  // Divider state register, cleared by reset even mid-division.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      sticky_q <= sticky_d;
    end
  end

  assign done_o   = last;
  assign quo_o    = quo_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/float_div.sv
// rtl/float_div.sv - sequential single-precision divider; FDIV_RNE_EN selects round-to-nearest-even, else truncate
module float_div
  import fdiv_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   flt_A,
  input  logic [EXP_W+FRAC_W:0]   flt_B,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   out_result,
  output logic [3:0]              out_flags
);

  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int M  = FRAC_W + 1;
  localparam int NQ = FRAC_W + 4;
  localparam int XW = EXP_W + 2;

  localparam logic signed [XW-1:0] BIAS_X  = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EMAX_X  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] ZERO_X  = '0;
  localparam logic signed [XW-1:0] ONE_X   = XW'(1);
  localparam logic [W-1:0]   QNAN_V  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic [W-2:0]   INF_MAG = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  fdiv_state_t state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic                  sign_q, sign_d;
  logic signed [XW-1:0]  exp_q, exp_d, exp_r;
  logic [M-1:0]          mant_q, mant_d;
  logic                  g_q, g_d, r_q, r_d, s_q, s_d;
  logic                  core_start, core_done, core_sticky, inc;
  logic [NQ-1:0]         core_quo;
  logic [M:0]            rounded;
  logic [FRAC_W-1:0]     frac_r;
  logic [EXP_W-1:0]      ea, eb;
  logic [FRAC_W-1:0]     fa, fb;
  logic                  sa, sb;
  fdiv_class_t           ca, cb;

  assign sa = a_q[W-1];
  assign sb = b_q[W-1];
  assign ea = a_q[W-2:FRAC_W];
  assign eb = b_q[W-2:FRAC_W];
  assign fa = a_q[FRAC_W-1:0];
  assign fb = b_q[FRAC_W-1:0];

  fdiv_mant_core #(.FRAC_W(FRAC_W)) u_core (
    .clk_i    (clk),
    .resetn_i (res),
    .start_i  (core_start),
    .mant_a_i ({1'b1, fa}),
    .mant_b_i ({1'b1, fb}),
    .done_o   (core_done),
    .quo_o    (core_quo),
    .sticky_o (core_sticky)
  );

  // Next-state and datapath: classify, divide, normalise, round, hold result.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    flags_d    = flags_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    g_d        = g_q;
    r_d        = r_q;
    s_d        = s_q;
    core_start = 1'b0;
    ca         = classify(ea == '0, &ea, fa == '0);
    cb         = classify(eb == '0, &eb, fb == '0);
`ifdef FDIV_RNE_EN
    inc        = g_q && (r_q || s_q || mant_q[0]);
`else
    // Guard/round/sticky are dropped: round toward zero.
    inc        = 1'b0 & (g_q | r_q | s_q);
`endif
    rounded    = {1'b0, mant_q} + {{M{1'b0}}, inc};
    frac_r     = rounded[M] ? rounded[FRAC_W:1] : rounded[FRAC_W-1:0];
    exp_r      = exp_q + {{(XW-1){1'b0}}, rounded[M]};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = flt_A;
          b_d     = flt_B;
          state_d = CHECK;
        end
      end
      CHECK: begin
        sign_d  = sa ^ sb;
        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_X;
        flags_d = '0;
        state_d = DONE;
        if (ca.is_nan || cb.is_nan || (ca.is_zero && cb.is_zero) || (ca.is_inf && cb.is_inf)) begin
          result_d               = QNAN_V;
          flags_d[FLAG_INVALID]  = 1'b1;
        end else if (cb.is_zero) begin
          result_d               = {sa ^ sb, INF_MAG};
          flags_d[FLAG_DIVZ]     = 1'b1;
        end else if (ca.is_inf) begin
          result_d               = {sa ^ sb, INF_MAG};
        end else if (ca.is_zero || cb.is_inf) begin
          result_d               = {sa ^ sb, {(W-1){1'b0}}};
        end else begin
          core_start             = 1'b1;
          state_d                = DIV;
        end
      end
      DIV: begin
        if (core_done) state_d = NORM;
      end
      NORM: begin
        if (core_quo[NQ-1]) begin
          mant_d = core_quo[NQ-1:3];
          g_d    = core_quo[2];
          r_d    = core_quo[1];
          s_d    = core_quo[0] | core_sticky;
        end else begin
          mant_d = core_quo[NQ-2:2];
          g_d    = core_quo[1];
          r_d    = core_quo[0];
          s_d    = core_sticky;
          exp_d  = exp_q - ONE_X;
        end
        state_d = ROUND;
      end
      ROUND: begin
        if (exp_r >= EMAX_X) begin
          result_d           = {sign_q, INF_MAG};
          flags_d[FLAG_OVF]  = 1'b1;
        end else if (exp_r <= ZERO_X) begin
          result_d           = {sign_q, {(W-1){1'b0}}};
          flags_d[FLAG_UDF]  = 1'b1;
        end else begin
          result_d           = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_float_div.sv
// tb/tb_float_div.sv - self-checking bench for float_div: directed cases plus randomized ops against an integer reference
module tb_float_div;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] flt_A, flt_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  float_div dut (
    .clk        (clk),
    .res        (res),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flt_A      (flt_A),
    .flt_B      (flt_B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer quotient with extra bits, then round/classify.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
    int     ea, eb, e, extra;
    longint ma, mb, num, q, rem, mant, rb, half;
    bit     s, za, zb, ia, ib, na, nb, up;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    f   = 4'b0000;
    lat = 1;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = 32'h7FC00000; f = 4'b1000;
    end else if (zb) begin
      r = {s, 31'h7F800000}; f = 4'b0100;
    end else if (ia) begin
      r = {s, 31'h7F800000};
    end else if (za || ib) begin
      r = {s, 31'h0};
    end else begin
      lat  = 30;
      ma   = longint'({1'b1, a[22:0]});
      mb   = longint'({1'b1, b[22:0]});
      num  = ma << 26;
      q    = num / mb;
      rem  = num % mb;
      e    = ea - eb + 127;
      if (q < (longint'(1) << 26)) begin
        extra = 2;
        e     = e - 1;
      end else begin
        extra = 3;
      end
      mant = q >> extra;
      rb   = q & ((longint'(1) << extra) - 1);
      half = longint'(1) << (extra - 1);
`ifdef FDIV_RNE_EN
      up = (rb > half) || ((rb == half) && ((rem != 0) || (mant[0] == 1'b1)));
`else
      up = 1'b0;
`endif
      mant = mant + longint'(up);
      if (mant == (longint'(1) << 24)) begin
        mant = mant >> 1;
        e    = e + 1;
      end
      if (e >= 255) begin
        r = {s, 31'h7F800000}; f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'h0}; f = 4'b0001;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] fr;
    logic        s;
    int          sel;
    sel = $urandom_range(0, 15);
    s   = 1'($urandom_range(0, 1));
    fr  = 23'($urandom);
    e   = 8'($urandom_range(1, 254));
    case (sel)
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, fr | 23'h1};
      3:       return {s, 8'h00, fr | 23'h1};
      default: return {s, e, fr};
    endcase
  endfunction

  // Issue one op, measure latency, optionally stall in DONE, then hand off.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input int hold,
                        input logic [31:0] er, input logic [3:0] ef, input int elat);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; flt_A = a; flt_B = b;
    @(posedge clk); #1;
    in_valid = 1'b0; flt_A = $urandom; flt_B = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_res"}, out_result, er);
    check_eq({tag, "_flg"}, 32'(out_flags), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0]; flt_A = $urandom; flt_B = $urandom;
      @(posedge clk); #1;
      check_eq({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_hold_res"}, out_result, er);
      check_eq({tag, "_hold_flg"}, 32'(out_flags), 32'(ef));
      check_eq({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_rdy_next"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
  } vec_t;

  vec_t dir[7];

  initial begin
    logic [31:0] er;
    logic [3:0]  ef;
    int          el;
    int          seen;
    logic [31:0] ra, rb;

    dir[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 30};
`ifdef FDIV_RNE_EN
    dir[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 30};
`else
    dir[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 30};
`endif
    dir[2] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1};
    dir[3] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1};
    dir[4] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1};
    dir[5] = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 30};
    dir[6] = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 30};

    res = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flt_A = '0; flt_B = '0;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_result", out_result, 32'h0);
    check_eq("rst_out_flags", 32'(out_flags), 32'h0);

    foreach (dir[i]) run_op("dir", dir[i].a, dir[i].b, 0, dir[i].r, dir[i].f, dir[i].lat);

    // Stall in DONE with in_valid pulses, then an immediate back-to-back op.
    run_op("stall", 32'h40C00000, 32'h40000000, 10, 32'h40400000, 4'b0000, 30);
    run_op("b2b", 32'h41200000, 32'h40A00000, 0, 32'h40000000, 4'b0000, 30);

    // Reset during DIV discards the op.
    in_valid = 1'b1; flt_A = 32'h40C00000; flt_B = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    res = 1'b0;
    @(posedge clk); #1;
    res = 1'b1;
    check_eq("midrst_vld", 32'(out_valid), 32'd0);
    check_eq("midrst_rdy", 32'(in_ready), 32'd1);
    check_eq("midrst_res", out_result, 32'h0);
    seen = 0;
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("midrst_no_out", 32'(seen), 32'd0);
    run_op("post_rst", 32'h41200000, 32'h40A00000, 0, 32'h40000000, 4'b0000, 30);

    for (int k = 0; k < 150; k++) begin
      ra = rand_operand();
      rb = rand_operand();
      ref_div(ra, rb, er, ef, el);
      run_op("rnd", ra, rb, $urandom_range(0, 2), er, ef, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
